// File: rtl/iir_notch_seq_ctrl.sv
// iir_notch_seq_ctrl: sequences notch changes (drain -> switch -> settle) around
// the dual-notch biquad, gating its input and qualifying its output.
// Optional feature macro: NOTCH_BYPASS_EN (adds a bypass port and a din delay line).
module iir_notch_seq_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FILT_LAT    = 3,
    parameter int unsigned FLUSH_LEN   = 4,
    parameter int unsigned SETTLE_LEN  = 256,
    parameter int unsigned CNT_W       = 9,
    parameter bit          RESET_NOTCH = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] filt_din,
    input  logic [DATA_W-1:0] filt_dout,
    output logic              notch_select,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              cfg_req,
    input  logic              cfg_notch,
    output logic              cfg_ack,
`ifdef NOTCH_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tgt_q, tgt_d;
    logic                notch_q, notch_d;
    logic [DATA_W-1:0]   filt_din_q, filt_din_d;
    logic                filt_vld_q, filt_vld_d;
    logic [FILT_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                cfg_ack_q, cfg_ack_d;
    logic                busy_q, busy_d;
    logic                masked;
    logic                zero_in;

`ifdef NOTCH_BYPASS_EN
    logic                              sel_f_q, sel_f_d;
    logic [FILT_LAT-1:0]               sel_pipe_q, sel_pipe_d;
    logic [FILT_LAT-1:0][DATA_W-1:0]   byp_dly_q, byp_dly_d;
`endif

    // Sequencer next state: request compare in RUN, sample-counted drain and settle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        notch_d   = notch_q;
        cfg_ack_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                // The clock after an ack is skipped so the requester can drop cfg_req.
                if (cfg_req && !cfg_ack_q) begin
                    if (cfg_notch == notch_q) begin
                        cfg_ack_d = 1'b1;
                    end else begin
                        tgt_d   = cfg_notch;
                        cnt_d   = CNT_W'(FLUSH_LEN);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (in_valid) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_SWITCH;
                    end
                end
            end
            ST_SWITCH: begin
                notch_d = tgt_q;
                cnt_d   = CNT_W'(SETTLE_LEN);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (in_valid) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d   = ST_RUN;
                        cfg_ack_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        busy_d = (state_d != ST_RUN);
    end

    // Data path: zero the filter input while draining, and carry a valid flag
    // alongside filt_din and then through FILT_LAT stages mirroring the filter.
    always_comb begin
        masked     = (state_q != ST_RUN);
        zero_in    = (state_q == ST_DRAIN) || (state_q == ST_SWITCH);
        filt_din_d = zero_in ? '0 : din;
        filt_vld_d = in_valid & ~masked;

        vld_pipe_d    = '0;
        vld_pipe_d[0] = filt_vld_q;
        for (int unsigned i = 1; i < FILT_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        dout_valid_d = vld_pipe_q[FILT_LAT-1];

`ifdef NOTCH_BYPASS_EN
        // Bypass select rides with each sample so a toggle never mixes sources.
        sel_f_d       = bypass & (state_q == ST_RUN);
        sel_pipe_d    = '0;
        sel_pipe_d[0] = sel_f_q;
        byp_dly_d     = '0;
        byp_dly_d[0]  = filt_din_q;
        for (int unsigned i = 1; i < FILT_LAT; i++) begin
            sel_pipe_d[i] = sel_pipe_q[i-1];
            byp_dly_d[i]  = byp_dly_q[i-1];
        end
        dout_d = sel_pipe_q[FILT_LAT-1] ? byp_dly_q[FILT_LAT-1] : filt_dout;
`else
        dout_d = filt_dout;
`endif
    end

    // State, counters, pipes and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            tgt_q        <= 1'b0;
            notch_q      <= RESET_NOTCH;
            filt_din_q   <= '0;
            filt_vld_q   <= 1'b0;
            vld_pipe_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            cfg_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef NOTCH_BYPASS_EN
            sel_f_q      <= 1'b0;
            sel_pipe_q   <= '0;
            byp_dly_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tgt_q        <= tgt_d;
            notch_q      <= notch_d;
            filt_din_q   <= filt_din_d;
            filt_vld_q   <= filt_vld_d;
            vld_pipe_q   <= vld_pipe_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cfg_ack_q    <= cfg_ack_d;
            busy_q       <= busy_d;
`ifdef NOTCH_BYPASS_EN
            sel_f_q      <= sel_f_d;
            sel_pipe_q   <= sel_pipe_d;
            byp_dly_q    <= byp_dly_d;
`endif
        end
    end

    assign filt_din     = filt_din_q;
    assign notch_select = notch_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign cfg_ack      = cfg_ack_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_iir_notch_seq_ctrl.sv
// Bench for iir_notch_seq_ctrl (default build): directed table, hand sequences,
// then randomized traffic against a sample-count reference model.
module tb_iir_notch_seq_ctrl;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FILT_LAT   = 3;
    localparam int unsigned FLUSH_LEN  = 4;
    localparam int unsigned SETTLE_LEN = 8;
    localparam int unsigned CNT_W      = 9;
    localparam int          LAT        = FILT_LAT + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] filt_din;
    logic [DATA_W-1:0] filt_dout;
    logic              notch_select;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              cfg_req;
    logic              cfg_notch;
    logic              cfg_ack;
    logic              busy;

    int total = 0;
    int bad   = 0;

    iir_notch_seq_ctrl #(
        .DATA_W(DATA_W), .FILT_LAT(FILT_LAT), .FLUSH_LEN(FLUSH_LEN),
        .SETTLE_LEN(SETTLE_LEN), .CNT_W(CNT_W), .RESET_NOTCH(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din),
        .filt_din(filt_din), .filt_dout(filt_dout), .notch_select(notch_select),
        .dout(dout), .dout_valid(dout_valid), .cfg_req(cfg_req),
        .cfg_notch(cfg_notch), .cfg_ack(cfg_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Filter stand-in: pure FILT_LAT-clock delay of filt_din.
    logic [DATA_W-1:0] fstage [FILT_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FILT_LAT; i++) fstage[i] <= '0;
        end else begin
            fstage[0] <= filt_din;
            for (int i = 1; i < FILT_LAT; i++) fstage[i] <= fstage[i-1];
        end
    end
    assign filt_dout = fstage[FILT_LAT-1];

    // Reference model: remaining flush samples, pending switch clock, remaining
    // settle samples; output = filter input seen LAT clocks earlier.
    bit                m_on = 1'b0;
    int                m_zero, m_settle;
    bit                m_sw, m_notch, m_tgt, m_ack, m_busy, m_dv;
    logic [DATA_W-1:0] m_fd, m_dout;
    logic [DATA_W-1:0] m_hd [LAT];
    bit                m_hv [LAT];

    task automatic model_reset();
        m_zero = 0; m_settle = 0; m_sw = 0; m_notch = 0; m_tgt = 0;
        m_ack = 0; m_busy = 0; m_dv = 0; m_fd = '0; m_dout = '0;
        for (int i = 0; i < LAT; i++) begin m_hd[i] = '0; m_hv[i] = 0; end
    endtask

    task automatic model_edge();
        bit                msk;
        bit                prev_ack;
        logic [DATA_W-1:0] fd;
        prev_ack = m_ack;
        m_ack    = 0;
        msk      = (m_zero > 0) || m_sw || (m_settle > 0);
        fd       = ((m_zero > 0) || m_sw) ? '0 : din;
        m_dout   = m_hd[LAT-1];
        m_dv     = m_hv[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin m_hd[i] = m_hd[i-1]; m_hv[i] = m_hv[i-1]; end
        m_hd[0] = fd;
        m_hv[0] = in_valid && !msk;
        m_fd    = fd;
        if (m_sw) begin
            m_notch = m_tgt; m_sw = 0; m_settle = int'(SETTLE_LEN);
        end else if (m_zero > 0) begin
            if (in_valid) begin m_zero--; if (m_zero == 0) m_sw = 1; end
        end else if (m_settle > 0) begin
            if (in_valid) begin m_settle--; if (m_settle == 0) m_ack = 1; end
        end else if (cfg_req && !prev_ack) begin
            if (cfg_notch == m_notch) m_ack = 1;
            else begin m_tgt = cfg_notch; m_zero = int'(FLUSH_LEN); end
        end
        m_busy = (m_zero > 0) || m_sw || (m_settle > 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (m_on) model_edge();
        #1;
    endtask

    typedef struct {
        bit                busy;
        bit                notch;
        bit                ack;
        logic [DATA_W-1:0] fd;
        bit                dv;
    } row_t;
    row_t tbl [19];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ack_e, vs;
        bit  req_active, hold;

        // Expected per-clock outputs of a 1-notch switch (flush 4, settle 8), din=100.
        tbl[0]  = '{1, 0, 0, 100, 1};
        tbl[1]  = '{1, 0, 0,   0, 1};
        tbl[2]  = '{1, 0, 0,   0, 1};
        tbl[3]  = '{1, 0, 0,   0, 1};
        tbl[4]  = '{1, 0, 0,   0, 1};
        tbl[5]  = '{1, 1, 0,   0, 0};
        tbl[6]  = '{1, 1, 0, 100, 0};
        tbl[7]  = '{1, 1, 0, 100, 0};
        tbl[8]  = '{1, 1, 0, 100, 0};
        tbl[9]  = '{1, 1, 0, 100, 0};
        tbl[10] = '{1, 1, 0, 100, 0};
        tbl[11] = '{1, 1, 0, 100, 0};
        tbl[12] = '{1, 1, 0, 100, 0};
        tbl[13] = '{0, 1, 1, 100, 0};
        tbl[14] = '{0, 1, 0, 100, 0};
        tbl[15] = '{0, 1, 0, 100, 0};
        tbl[16] = '{0, 1, 0, 100, 0};
        tbl[17] = '{0, 1, 0, 100, 0};
        tbl[18] = '{0, 1, 0, 100, 1};

        // Reset values
        rst_n = 1'b0; in_valid = 1'b0; din = '0; cfg_req = 1'b0; cfg_notch = 1'b0;
        step(); step(); step();
        chk("rst_filt_din", filt_din, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_cfg_ack", cfg_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_notch", notch_select, 0);

        // First-sample latency
        rst_n = 1'b1; in_valid = 1'b1; din = 16'd100;
        for (int n = 1; n <= 6; n++) begin
            step();
            chk("lat_dout_valid", dout_valid, (n >= 5) ? 1 : 0);
            if (n >= 5) chk("lat_dout", dout, 100);
            chk("lat_notch", notch_select, 0);
        end

        // Table-driven switch to notch 1
        cfg_req = 1'b1; cfg_notch = 1'b1;
        for (int e = 0; e < 19; e++) begin
            step();
            chk("tbl_busy", busy, tbl[e].busy);
            chk("tbl_notch", notch_select, tbl[e].notch);
            chk("tbl_ack", cfg_ack, tbl[e].ack);
            chk("tbl_filt_din", filt_din, tbl[e].fd);
            chk("tbl_dout_valid", dout_valid, tbl[e].dv);
            if (tbl[e].dv) chk("tbl_dout", dout, 100);
            if (tbl[e].ack) cfg_req = 1'b0;
        end

        // Same-notch request: immediate ack, no flush
        cfg_req = 1'b1; cfg_notch = 1'b1;
        step();
        chk("same_ack", cfg_ack, 1);
        chk("same_busy", busy, 0);
        chk("same_dv", dout_valid, 1);
        cfg_req = 1'b0;
        for (int e = 0; e < 6; e++) begin
            step();
            chk("same_ack_after", cfg_ack, 0);
            chk("same_busy_after", busy, 0);
            chk("same_dv_after", dout_valid, 1);
        end

        // Alternate-clock in_valid: duration counts samples, not clocks
        cfg_req = 1'b1; cfg_notch = 1'b0; ack_e = -1; vs = 0;
        for (int e = 0; e < 60; e++) begin
            in_valid = (e % 2 == 0);
            step();
            if (e > 0 && in_valid) vs++;
            if (cfg_ack) begin ack_e = e; break; end
        end
        cfg_req = 1'b0; in_valid = 1'b1;
        chk("alt_ack_clock", ack_e, 24);
        chk("alt_valid_samples", vs, 12);
        chk("alt_notch", notch_select, 0);

        // Reset during SETTLE aborts without ack
        step();
        cfg_req = 1'b1; cfg_notch = 1'b1;
        for (int e = 0; e < 8; e++) step();
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0; cfg_req = 1'b0;
        #1;
        chk("midrst_notch", notch_select, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dv", dout_valid, 0);
        chk("midrst_ack", cfg_ack, 0);
        step(); chk("midrst_ack_hold", cfg_ack, 0);
        rst_n = 1'b1;
        cfg_req = 1'b1; cfg_notch = 1'b1; ack_e = -1;
        for (int e = 0; e < 40; e++) begin
            step();
            if (cfg_ack) begin ack_e = e; break; end
        end
        cfg_req = 1'b0;
        chk("post_rst_ack_clock", ack_e, 13);
        chk("post_rst_notch", notch_select, 1);

        // Randomized traffic against the reference model
        rst_n = 1'b0; in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        model_reset();
        m_on = 1'b1;
        req_active = 0; hold = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            din      = DATA_W'($urandom);
            if (!req_active && $urandom_range(0, 15) == 0) begin
                cfg_req = 1'b1; cfg_notch = 1'($urandom); req_active = 1;
            end
            step();
            chk("rnd_filt_din", filt_din, m_fd);
            chk("rnd_notch", notch_select, m_notch);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_ack", cfg_ack, m_ack);
            chk("rnd_dout_valid", dout_valid, m_dv);
            chk("rnd_dout", dout, m_dout);
            if (hold) begin
                cfg_req = 1'b0; req_active = 0; hold = 0;
            end else if (req_active && m_ack) begin
                if ($urandom_range(0, 1) == 1) hold = 1;
                else begin cfg_req = 1'b0; req_active = 0; end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
